// File: rtl/bet_entry_pkg.sv
// Shared definitions for the roulette bet-entry stage and its neighbours.
// Holds the FSM state encoding, slot/bet geometry and the stake and money constants
// that are also used by the money manager.
package bet_entry_pkg;

  typedef enum logic {
    ST_EDIT   = 1'b0,
    ST_LOCKED = 1'b1
  } bet_state_t;

  localparam int          NUM_SLOTS     = 16;
  localparam int          MAX_BETS      = 4;
  localparam logic [15:0] AMT_STEP      = 16'd10;
  localparam logic [15:0] AMT_MAX       = 16'd110;
  localparam logic [15:0] INITIAL_MONEY = 16'd100;
  localparam logic [15:0] MAX_MONEY     = 16'd9990;

endpackage

// File: rtl/bet_entry_bet_list.sv
// bet_list: LIFO of up to MAX_BETS 4-bit slot numbers with a one-hot membership mask.
// Ports: clk/rst, i_clr (sync clear), i_push/i_num (append), i_pop (drop newest);
//        o_count, o_nums (entry 0 in [3:0]), o_mask, o_full, o_empty, o_dup (i_num already listed).
// All outputs come straight from registers; the caller decides whether a push/pop is legal.
module bet_list
  import bet_entry_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [3:0]           i_num,
  output logic [2:0]           o_count,
  output logic [15:0]          o_nums,
  output logic [NUM_SLOTS-1:0] o_mask,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_dup
);

  logic [2:0]           r_count;
  logic [15:0]          r_nums;
  logic [NUM_SLOTS-1:0] r_mask;
  logic [1:0]           w_top_idx;
  logic [3:0]           w_top_num;

  // Newest entry sits at count-1; only meaningful when the list is non-empty.
  assign w_top_idx = 2'(r_count - 3'd1);
  assign w_top_num = r_nums[{w_top_idx, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 3'd0;
      r_nums  <= 16'd0;
      r_mask  <= '0;
    end else if (i_clr) begin
      r_count <= 3'd0;
      r_nums  <= 16'd0;
      r_mask  <= '0;
    end else if (i_pop) begin
      r_nums[{w_top_idx, 2'b00} +: 4] <= 4'd0;
      r_mask[w_top_num]               <= 1'b0;
      r_count                         <= r_count - 3'd1;
    end else if (i_push) begin
      r_nums[{r_count[1:0], 2'b00} +: 4] <= i_num;
      r_mask[i_num]                      <= 1'b1;
      r_count                            <= r_count + 3'd1;
    end
  end

  assign o_count = r_count;
  assign o_nums  = r_nums;
  assign o_mask  = r_mask;
  assign o_full  = (r_count == 3'(MAX_BETS));
  assign o_empty = (r_count == 3'd0);
  assign o_dup   = r_mask[i_num];

endmodule

// File: rtl/bet_entry.sv
// bet_entry: collects bet numbers and stake in EDIT, locks them for the round in LOCKED.
// Ports: clk/rst, game_reset, key_add/del/up/dn/confirm pulses, sw_num, current_money, spin_done;
//        bet_amount, bet_count, bet_nums, bet_mask, bet_ready, err_pulse (all registered, 1-cycle latency).
// Optional build macro BET_REPEAT_EN: keep the number list across spin_done so the bet can be repeated.
module bet_entry
  import bet_entry_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 game_reset,
  input  logic                 key_add,
  input  logic                 key_del,
  input  logic                 key_up,
  input  logic                 key_dn,
  input  logic                 key_confirm,
  input  logic [3:0]           sw_num,
  input  logic [15:0]          current_money,
  input  logic                 spin_done,
  output logic [15:0]          bet_amount,
  output logic [2:0]           bet_count,
  output logic [15:0]          bet_nums,
  output logic [NUM_SLOTS-1:0] bet_mask,
  output logic                 bet_ready,
  output logic                 err_pulse
);

  bet_state_t  r_state, w_state_nxt;
  logic [15:0] r_amount, w_amt_nxt;
  logic        r_err, w_err_nxt;
  logic        w_push, w_pop, w_clr;
  logic        w_full, w_empty, w_dup, w_sw_bad, w_confirm_ok;
  logic [15:0] w_cap, w_floor, w_up_amt, w_dn_amt;
  logic [16:0] w_up_sum;

  bet_list u_list (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_num   (sw_num),
    .o_count (bet_count),
    .o_nums  (bet_nums),
    .o_mask  (bet_mask),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dup   (w_dup)
  );

  // Stake ceiling is the smaller of balance and the table limit; the sum is
  // formed in 17 bits so a near-full 16-bit stake cannot wrap before the compare.
  assign w_cap    = (current_money < AMT_MAX) ? current_money : AMT_MAX;
  assign w_up_sum = {1'b0, r_amount} + {1'b0, AMT_STEP};
  assign w_up_amt = (w_up_sum > {1'b0, w_cap}) ? w_cap : w_up_sum[15:0];

  // A player short of one step can still stake everything they have.
  assign w_floor  = (current_money < AMT_STEP) ? current_money : AMT_STEP;
  assign w_dn_amt = ({1'b0, r_amount} >= ({1'b0, w_floor} + {1'b0, AMT_STEP}))
                    ? (r_amount - AMT_STEP) : w_floor;

  assign w_sw_bad     = ({1'b0, sw_num} >= 5'(NUM_SLOTS));
  assign w_confirm_ok = !w_empty && (r_amount != 16'd0) && (r_amount <= current_money);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EDIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_amt_nxt   = r_amount;
    w_err_nxt   = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    if (game_reset) begin
      w_state_nxt = ST_EDIT;
      w_amt_nxt   = AMT_STEP;
      w_clr       = 1'b1;
    end else if (r_state == ST_LOCKED) begin
      // Keys are ignored and the bet is frozen until the round settles.
      if (spin_done) begin
        w_state_nxt = ST_EDIT;
`ifdef BET_REPEAT_EN
        w_clr       = 1'b0;
`else
        w_clr       = 1'b1;
`endif
      end
    end else begin
      // Balance clamp is the default; an up/dn in the same cycle overrides it.
      if (r_amount > current_money) w_amt_nxt = current_money;
      if (key_confirm) begin
        if (w_confirm_ok) w_state_nxt = ST_LOCKED;
        else              w_err_nxt   = 1'b1;
      end else if (key_del) begin
        if (w_empty) w_err_nxt = 1'b1;
        else         w_pop     = 1'b1;
      end else if (key_add) begin
        if (w_full || w_sw_bad || w_dup) w_err_nxt = 1'b1;
        else                             w_push    = 1'b1;
      end else if (key_up) begin
        w_amt_nxt = w_up_amt;
      end else if (key_dn) begin
        w_amt_nxt = w_dn_amt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_amount <= AMT_STEP;
      r_err    <= 1'b0;
    end else begin
      r_amount <= w_amt_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign bet_amount = r_amount;
  assign bet_ready  = (r_state == ST_LOCKED);
  assign err_pulse  = r_err;

endmodule

// File: tb/tb_bet_entry.sv
// Directed self-checking bench for bet_entry (default build; BET_REPEAT_EN expectations guarded).
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
// Key vector bit order: {confirm, del, add, up, dn}.
module tb_bet_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_reset = 1'b0;
  logic [4:0]  keys = 5'd0;
  logic [3:0]  sw_num = 4'd0;
  logic [15:0] current_money = 16'd100;
  logic        spin_done = 1'b0;
  logic [15:0] bet_amount;
  logic [2:0]  bet_count;
  logic [15:0] bet_nums;
  logic [15:0] bet_mask;
  logic        bet_ready;
  logic        err_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int errs_seen;

  localparam logic [4:0] K_DN = 5'b00001, K_UP = 5'b00010, K_ADD = 5'b00100,
                         K_DEL = 5'b01000, K_CONF = 5'b10000;

  always #5 clk = ~clk;

  bet_entry dut (
    .clk           (clk),
    .rst           (rst),
    .game_reset    (game_reset),
    .key_add       (keys[2]),
    .key_del       (keys[3]),
    .key_up        (keys[1]),
    .key_dn        (keys[0]),
    .key_confirm   (keys[4]),
    .sw_num        (sw_num),
    .current_money (current_money),
    .spin_done     (spin_done),
    .bet_amount    (bet_amount),
    .bet_count     (bet_count),
    .bet_nums      (bet_nums),
    .bet_mask      (bet_mask),
    .bet_ready     (bet_ready),
    .err_pulse     (err_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One-cycle key pulse; err_pulse is accumulated for the step it reports on.
  task automatic press(input logic [4:0] k, input logic [3:0] n);
    keys   = k;
    sw_num = n;
    @(negedge clk);
    keys = 5'd0;
    errs_seen += int'(err_pulse);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_amount", 32'(bet_amount), 32'd10);
    chk("rst_count",  32'(bet_count),  32'd0);
    chk("rst_nums",   32'(bet_nums),   32'd0);
    chk("rst_mask",   32'(bet_mask),   32'd0);
    chk("rst_ready",  32'(bet_ready),  32'd0);
    chk("rst_err",    32'(err_pulse),  32'd0);

    // Confirm on an empty list is rejected.
    errs_seen = 0;
    press(K_CONF, 4'd0);
    chk("conf_empty_err",   32'(errs_seen), 32'd1);
    chk("conf_empty_ready", 32'(bet_ready), 32'd0);

    // Add 3, 7, 3: the duplicate is rejected once.
    errs_seen = 0;
    press(K_ADD, 4'd3);
    press(K_ADD, 4'd7);
    press(K_ADD, 4'd3);
    chk("dup_err_now", 32'(err_pulse), 32'd1);
    idle(1);
    chk("dup_err_one_cycle", 32'(err_pulse), 32'd0);
    chk("dup_err_total", 32'(errs_seen), 32'd1);
    chk("add_count", 32'(bet_count), 32'd2);
    chk("add_nums",  32'(bet_nums[7:0]), 32'h73);
    chk("add_mask",  32'(bet_mask), 32'h0088);

    // Stake up to balance ceiling, then down to the floor; never an error.
    errs_seen = 0;
    for (int i = 0; i < 12; i++) press(K_UP, 4'd0);
    chk("up_sat_100", 32'(bet_amount), 32'd100);
    for (int i = 0; i < 15; i++) press(K_DN, 4'd0);
    chk("dn_floor_10", 32'(bet_amount), 32'd10);
    current_money = 16'd55;
    for (int i = 0; i < 6; i++) press(K_UP, 4'd0);
    chk("up_sat_55", 32'(bet_amount), 32'd55);
    for (int i = 0; i < 5; i++) press(K_DN, 4'd0);
    chk("dn_55_to_10", 32'(bet_amount), 32'd10);
    chk("stake_no_err", 32'(errs_seen), 32'd0);
    current_money = 16'd100;
    for (int i = 0; i < 5; i++) press(K_UP, 4'd0);
    chk("up_to_60", 32'(bet_amount), 32'd60);

    // Lock, then keys are ignored and the bet is frozen.
    errs_seen = 0;
    press(K_CONF, 4'd0);
    chk("lock_ready", 32'(bet_ready), 32'd1);
    press(K_ADD, 4'd9);
    press(K_UP, 4'd0);
    chk("lock_count", 32'(bet_count), 32'd2);
    chk("lock_mask",  32'(bet_mask),  32'h0088);
    chk("lock_amt",   32'(bet_amount), 32'd60);
    chk("lock_no_err", 32'(errs_seen), 32'd0);
    current_money = 16'd40;
    idle(2);
    chk("lock_amt_frozen", 32'(bet_amount), 32'd60);

    // Round settles: list handling depends on the build, stake clamps a cycle later.
    spin_done = 1'b1;
    @(negedge clk);
    spin_done = 1'b0;
    chk("spin_ready", 32'(bet_ready), 32'd0);
`ifdef BET_REPEAT_EN
    chk("spin_count", 32'(bet_count), 32'd2);
    chk("spin_mask",  32'(bet_mask),  32'h0088);
`else
    chk("spin_count", 32'(bet_count), 32'd0);
    chk("spin_mask",  32'(bet_mask),  32'h0000);
    chk("spin_nums",  32'(bet_nums),  32'h0000);
`endif
    chk("spin_amt_kept", 32'(bet_amount), 32'd60);
    idle(1);
    chk("spin_amt_clamp", 32'(bet_amount), 32'd40);

    // spin_done in EDIT does nothing.
    spin_done = 1'b1;
    @(negedge clk);
    spin_done = 1'b0;
    chk("spin_in_edit", 32'(bet_ready), 32'd0);

`ifdef BET_REPEAT_EN
    press(K_DEL, 4'd0);
    press(K_DEL, 4'd0);
`endif
    // Fill the list, overflow, then confirm beats add in the same cycle.
    current_money = 16'd100;
    errs_seen = 0;
    press(K_ADD, 4'd1);
    press(K_ADD, 4'd2);
    press(K_ADD, 4'd3);
    press(K_ADD, 4'd4);
    chk("full_nums", 32'(bet_nums), 32'h4321);
    chk("full_mask", 32'(bet_mask), 32'h001E);
    press(K_ADD, 4'd5);
    chk("full_err",   32'(errs_seen), 32'd1);
    chk("full_count", 32'(bet_count), 32'd4);
    press(K_CONF | K_ADD, 4'd6);
    chk("conf_wins_ready", 32'(bet_ready), 32'd1);
    chk("conf_wins_count", 32'(bet_count), 32'd4);
    chk("conf_wins_err",   32'(err_pulse), 32'd0);

    // Synchronous game reset out of LOCKED.
    game_reset = 1'b1;
    @(negedge clk);
    game_reset = 1'b0;
    chk("grst_ready", 32'(bet_ready), 32'd0);
    chk("grst_amt",   32'(bet_amount), 32'd10);
    chk("grst_count", 32'(bet_count), 32'd0);
    chk("grst_mask",  32'(bet_mask), 32'd0);

    // Coinciding pulses: up beats dn; del (on empty, error) beats add.
    press(K_UP | K_DN, 4'd0);
    chk("up_over_dn", 32'(bet_amount), 32'd20);
    press(K_DEL | K_ADD, 4'd6);
    chk("del_over_add_err",   32'(err_pulse), 32'd1);
    chk("del_over_add_count", 32'(bet_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
